// File: rtl/counter_pkg.sv
// Shared constants and helpers for the step_counter family.
package counter_pkg;

    localparam logic DIR_UP    = 1'b0;
    localparam logic DIR_DOWN  = 1'b1;
    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    // Clamp a value into [lo, hi]; used for out-of-range loads.
    function automatic int unsigned clamp(input int unsigned value,
                                          input int unsigned lo,
                                          input int unsigned hi);
        if (value < lo) return lo;
        if (value > hi) return hi;
        return value;
    endfunction

endpackage

// File: rtl/step_counter_next.sv
// Next-count arithmetic for step_counter: range-aware up/down step with wrap or saturate.
module step_counter_next
    import counter_pkg::*;
#(
    parameter int unsigned N       = 8,
    parameter int unsigned SW      = 2,
    parameter int unsigned MIN_VAL = 0,
    parameter int unsigned MAX_VAL = (1 << N) - 1
) (
    input  logic [N-1:0]  count,
    input  logic          UpDown,
    input  logic [SW-1:0] step,
    input  logic          sat,
    output logic [N-1:0]  next_count,
    output logic          ovf
);

    // One extra bit keeps sums and wrap offsets from aliasing at 2^N.
    localparam int unsigned W     = N + 1;
    localparam int unsigned R     = MAX_VAL - MIN_VAL + 1;
    localparam logic [W-1:0] MIN_W = W'(MIN_VAL);
    localparam logic [W-1:0] MAX_W = W'(MAX_VAL);
    localparam logic [W-1:0] R_W   = W'(R);

    logic [W-1:0] count_w;
    logic [W-1:0] step_w;
    logic [W-1:0] sum;
    logic [W-1:0] floor_w;
    logic [W-1:0] wrap_dn;

    assign count_w = W'(count);
    assign step_w  = W'(step);

    always_comb begin
        next_count = count;
        ovf        = 1'b0;
        sum        = count_w + step_w;
        floor_w    = MIN_W + step_w;
        wrap_dn    = count_w + R_W - step_w;
        if (UpDown == DIR_UP) begin
            if (sum <= MAX_W) begin
                next_count = N'(sum);
            end else begin
                ovf        = 1'b1;
                next_count = (sat == MODE_SAT) ? N'(MAX_VAL) : N'(sum - R_W);
            end
        end else begin
            // count - step >= MIN rewritten so nothing goes negative.
            if (count_w >= floor_w) begin
                next_count = N'(count_w - step_w);
            end else begin
                ovf        = 1'b1;
                next_count = (sat == MODE_SAT) ? N'(MIN_VAL) : N'(wrap_dn);
            end
        end
    end

endmodule

// File: rtl/step_counter.sv
// Range-limited up/down counter with run-time step, wrap/saturate, carry/borrow pulses and sticky load error.
module step_counter
    import counter_pkg::*;
#(
    parameter int unsigned N         = 8,
    parameter int unsigned SW        = 2,
    parameter int unsigned MIN_VAL   = 0,
    parameter int unsigned MAX_VAL   = (1 << N) - 1,
    parameter int unsigned RESET_VAL = MIN_VAL
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic          UpDown,
    input  logic [SW-1:0] step,
    input  logic          sat,
    input  logic          clear,
    input  logic          load,
    input  logic [N-1:0]  load_val,
    output logic [N-1:0]  count,
    output logic          at_max,
    output logic          at_min,
    output logic          carry,
    output logic          borrow,
    output logic          err
);

    localparam logic [N-1:0] MIN_N = N'(MIN_VAL);
    localparam logic [N-1:0] MAX_N = N'(MAX_VAL);
    localparam logic [N-1:0] RST_N = N'(RESET_VAL);

    if (MIN_VAL > MAX_VAL || longint'(MAX_VAL) > (longint'(1) << N) - 1) begin : g_bad_range
        $error("step_counter: need MIN_VAL <= MAX_VAL <= 2^N-1");
    end
    if (RESET_VAL < MIN_VAL || RESET_VAL > MAX_VAL) begin : g_bad_reset
        $error("step_counter: RESET_VAL outside [MIN_VAL, MAX_VAL]");
    end
    if ((1 << SW) - 1 > MAX_VAL - MIN_VAL + 1) begin : g_bad_step
        $error("step_counter: largest step exceeds range size");
    end

    logic [N-1:0] next_count;
    logic         ovf;
    logic [N-1:0] load_clamped;
    logic [N-1:0] count_d;
    logic         carry_d;
    logic         borrow_d;
    logic         err_d;

    step_counter_next #(
        .N       (N),
        .SW      (SW),
        .MIN_VAL (MIN_VAL),
        .MAX_VAL (MAX_VAL)
    ) u_next (
        .count      (count),
        .UpDown     (UpDown),
        .step       (step),
        .sat        (sat),
        .next_count (next_count),
        .ovf        (ovf)
    );

    assign load_clamped = N'(clamp(32'(load_val), MIN_VAL, MAX_VAL));

    // Priority: clear > load > enabled non-zero step > hold.
    always_comb begin
        count_d  = count;
        carry_d  = 1'b0;
        borrow_d = 1'b0;
        err_d    = err;
        if (clear) begin
            count_d = RST_N;
            err_d   = 1'b0;
        end else if (load) begin
            count_d = load_clamped;
            err_d   = err | (load_clamped != load_val);
        end else if (en && step != '0) begin
            count_d  = next_count;
            carry_d  = ovf && (UpDown == DIR_UP);
            borrow_d = ovf && (UpDown == DIR_DOWN);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count  <= RST_N;
            carry  <= 1'b0;
            borrow <= 1'b0;
            err    <= 1'b0;
        end else begin
            count  <= count_d;
            carry  <= carry_d;
            borrow <= borrow_d;
            err    <= err_d;
        end
    end

    assign at_max = (count == MAX_N);
    assign at_min = (count == MIN_N);

endmodule

// File: doc/step_counter.md
Name: step_counter

Overview:
Parametrised successor to the team's 2-bit-step binary up/down counter. Counts up or down by a run-time step of 0..2^SW-1 within a configurable range [MIN_VAL, MAX_VAL]. Range overrun either wraps modulo the range or saturates, selected per cycle. Used for credit/stock tallies and per-digit display counters; carry/borrow pulses allow BCD-style digit chaining.

Parameters:
N, 8, count width in bits
SW, 2, step input width; step range 0..2^SW-1
MIN_VAL, 0, lowest legal count
MAX_VAL, 2^N-1, highest legal count; MIN_VAL <= MAX_VAL <= 2^N-1
RESET_VAL, MIN_VAL, count value after reset/clear; must satisfy MIN_VAL <= RESET_VAL <= MAX_VAL
Elaboration-time check: 2^SW-1 <= MAX_VAL-MIN_VAL+1; otherwise $error.

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
en  in  1  step enable
UpDown  in  1  direction: 0 = up, 1 = down
step  in  SW  step magnitude; 0 = hold
sat  in  1  overrun mode: 1 = saturate, 0 = wrap
clear  in  1  synchronous return to RESET_VAL
load  in  1  synchronous load of load_val
load_val  in  N  value to load
count  out  N  registered count
at_max  out  1  combinational: count == MAX_VAL
at_min  out  1  combinational: count == MIN_VAL
carry  out  1  registered 1-cycle pulse: up step crossed MAX_VAL
borrow  out  1  registered 1-cycle pulse: down step crossed MIN_VAL
err  out  1  sticky: load_val was out of range; cleared only by reset or clear

Behaviour:
- Reset (async, active-high): count=RESET_VAL, carry=0, borrow=0, err=0. Deassertion takes effect at the next edge; no step occurs on the deasserting edge unless en is high then.
- Per-edge priority: clear > load > (en && step!=0) > hold.
- clear: count=RESET_VAL, err=0, carry/borrow=0.
- load: count=load_val clamped to [MIN_VAL, MAX_VAL]. err set if clamping occurred. carry/borrow=0.
- Step arithmetic uses N+1 bits to avoid native 2^N wrap. Let R = MAX_VAL-MIN_VAL+1.
- Up, sum = count+step:
  - sum <= MAX_VAL: count=sum, carry=0.
  - Otherwise, wrap (sat=0): count = sum-R, carry=1.
  - Otherwise, saturate (sat=1): count = MAX_VAL, carry=1.
- Down, diff = count-step (signed):
  - diff >= MIN_VAL: count=diff, borrow=0.
  - Otherwise, wrap: count = diff+R, borrow=1.
  - Otherwise, saturate: count = MIN_VAL, borrow=1.
- Saturating at a bound already reached still pulses carry/borrow; this marks a rejected credit.
- step==0 or en==0: count holds, carry=borrow=0.
- Latency: one cycle from input to count/carry/borrow.
- Pulses last exactly one cycle per qualifying edge. Back-to-back overruns give back-to-back pulses.
- count never leaves [MIN_VAL, MAX_VAL] under any input sequence.
- Reset asserted mid-sequence overrides everything immediately, including a concurrent load or clear.

Decomposition:
- Shared package counter_pkg:
  - direction constants DIR_UP=0, DIR_DOWN=1
  - mode constants MODE_WRAP=0, MODE_SAT=1
  - function clamp(value, lo, hi) for load handling
- One sub-module is natural: step_counter_next, combinational. Inputs are count, UpDown, step and sat; outputs are next_count and ovf. It holds all range arithmetic, so the top level is only the register, priority mux and flags.
- Digit chains are built by instantiating step_counter with en tied to the lower digit's carry. This is not a separate module.

Test Plan:
- Wrap up, N=4, MIN=0, MAX=9, SW=2: from count=8, UpDown=0, step=2, sat=0 -> count=0, carry=1 for one cycle. A further step=1 -> count=1, carry=0.
- Saturate down, same config: count=1, UpDown=1, step=3, sat=1 -> count=0, borrow=1. Repeat -> count stays 0, borrow=1 again. at_min=1 throughout.
- Load clamp, MIN=2, MAX=9: load=1, load_val=12 -> count=9, err=1, at_max=1. Then clear=1 -> count=RESET_VAL (2), err=0.
- Priority: in one cycle clear=1, load=1, en=1, step=2 -> count=RESET_VAL. Then load=1, load_val=5, en=1 -> count=5, no step applied.
- Async reset mid-operation: count=7 with en=1, step=1; assert reset between edges -> count=RESET_VAL and carry=borrow=err=0 immediately. Hold reset over 2 edges -> no change. Release reset -> counting resumes on the next edge.
- Randomised regression, 10k cycles, against a reference model: compare count, carry, borrow and err each cycle. Assert count stays in range and pulses never last more than one cycle without a fresh cause.
